preproc: RTL and testbench

Front-end of the filter datapath: the input-side counterpart to the back-end that collects the filter output and splits it down by 3. Accepts signed DWIDTH samples over a valid/ready handshake and buffers them in a small FIFO. Emits a continuous upsampled-by-FACTOR stream toward the NR_STAGES filter chain: each input sample at phase 0, zero at the remaining FACTOR-1 phases. Phase is exported so downstream stages stay aligned with the decimating back-end.

---
 rtl/preproc_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/preproc.sv | 118 +++++++++++
 tb/tb_preproc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/preproc_pkg.sv
// Shared definitions for the upsampling front-end: state encoding,
// default sizing and the width helper used for phase/pointer/count buses.
package preproc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_FACTOR     = 3;
    localparam int DEF_FIFO_DEPTH = 4;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head read.
// Latency: a write at edge E is visible at the head after E (poppable from E+1).
// Backpressure: push ignored when full, pop ignored when empty; push+pop allowed together.
module sync_fifo
    import preproc_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  logic                                pop,
    input  logic signed [0:DWIDTH-1]            wdata,
    output logic signed [0:DWIDTH-1]            rdata,
    output logic [clog2(FIFO_DEPTH+1)-1:0]      count,
    output logic                                full,
    output logic                                empty
);

    localparam int PW = clog2(FIFO_DEPTH);
    localparam int CW = clog2(FIFO_DEPTH + 1);

    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic signed [0:DWIDTH-1] mem_q [FIFO_DEPTH];
    logic signed [0:DWIDTH-1] mem_d [FIFO_DEPTH];
    logic                     do_push;
    logic                     do_pop;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally since the depth is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/preproc.sv
// Upsample-by-FACTOR front-end: FIFO-buffered input, sample at phase 0, zeros elsewhere.
// Latency: sample accepted at E into an empty idle block appears on data_out after E+1.
// Backpressure: in_ready low only while the FIFO holds FIFO_DEPTH samples.
module preproc
    import preproc_pkg::*;
#(
    parameter int NR_STAGES  = 32,
    parameter int DWIDTH     = 16,
    parameter int FACTOR     = DEF_FACTOR,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [0:DWIDTH-1]      data_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [0:DWIDTH-1]      data_out,
    output logic                          out_valid,
    output logic [clog2(FACTOR)-1:0]      phase,
    output logic                          underrun
);

    localparam int PW = clog2(FACTOR);
    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(FACTOR - 1);

    if (FACTOR < 2 || NR_STAGES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("preproc: unsupported parameter combination");
    end

    state_t                   state_q, state_d;
    logic [PW-1:0]            phase_q, phase_d;
    logic signed [0:DWIDTH-1] data_q, data_d;
    logic                     vld_q, vld_d;
    logic                     underrun_q, underrun_d;

    logic                     fifo_pop;
    logic signed [0:DWIDTH-1] fifo_head;
    logic [CW-1:0]            fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;

    assign in_ready = (fifo_count != CW'(FIFO_DEPTH));

    sync_fifo #(
        .DWIDTH     (DWIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid & ~fifo_full),
        .pop   (fifo_pop),
        .wdata (data_in),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        data_d     = '0;
        vld_d      = vld_q;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                vld_d   = 1'b0;
                phase_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_head;
                    vld_d    = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                vld_d = 1'b1;
                if (phase_q == LAST_PHASE) begin
                    phase_d = '0;
                    // An empty FIFO here costs one sample slot; cadence is never stretched.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        data_d   = fifo_head;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            underrun_q <= underrun_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = vld_q;
    assign phase     = phase_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_preproc.sv
// Randomized and directed bench for preproc against a queue-based stream model.
module tb_preproc;

    localparam int DW    = 16;
    localparam int F     = 3;
    localparam int DEPTH = 4;
    localparam int LIMIT = 50;

    logic                 clk;
    logic                 rst;
    logic signed [0:DW-1] data_in;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [0:DW-1] data_out;
    logic                 out_valid;
    logic [1:0]           phase;
    logic                 underrun;

    int checks   = 0;
    int failures = 0;

    // Stream model: FIFO as a queue, output computed from phase arithmetic.
    int mq[$];
    bit started  = 0;
    int mphase   = 0;
    int mdata    = 0;
    bit mvld     = 0;
    bit munder   = 0;
    bit m_ready;
    int m_din;

    int cap[$];
    int rdy_low = 0;

    preproc #(
        .NR_STAGES  (32),
        .DWIDTH     (DW),
        .FACTOR     (F),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .phase     (phase),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            started = 0;
            mphase  = 0;
            mdata   = 0;
            mvld    = 0;
            munder  = 0;
        end else begin
            m_ready = (mq.size() < DEPTH);
            m_din   = int'(data_in);
            if (!started) begin
                if (mq.size() > 0) begin
                    mdata   = mq.pop_front();
                    mvld    = 1;
                    mphase  = 0;
                    started = 1;
                end
            end else begin
                mphase = (mphase + 1) % F;
                if (mphase != 0) begin
                    mdata = 0;
                end else if (mq.size() > 0) begin
                    mdata = mq.pop_front();
                end else begin
                    mdata  = 0;
                    munder = 1;
                end
            end
            if (in_valid === 1'b1 && m_ready) begin
                mq.push_back(m_din);
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, mq.size() != DEPTH);
        chk("out_valid", out_valid, mvld);
        chk("data_out", data_out, mdata);
        chk("phase", phase, mphase);
        chk("underrun", underrun, munder);
        if (out_valid === 1'b1) cap.push_back(int'(data_out));
        if (in_valid === 1'b1 && in_ready === 1'b0) rdy_low++;
    end

    task automatic send(input int v);
        int n;
        n = 0;
        @(negedge clk);
        data_in  = v[15:0];
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stuck low for %0d cycles, required high within %0d", n, LIMIT);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_phase", phase, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        cap.delete();
    endtask

    task automatic cap_chk(input string name, input int idx, input int exp);
        chk(name, (idx < cap.size()) ? cap[idx] : 32'sh7fff_ffff, exp);
    endtask

    initial begin
        int exp2[12];
        int n;
        exp2 = '{1, 0, 0, 2, 0, 0, 3, 0, 0, -5, 0, 0};
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_in_ready", in_ready, 1);
        chk("init_data_out", data_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single sample: latency and zero-stuffing.
        send(100);
        @(negedge clk);
        chk("t1_not_yet", out_valid, 0);
        @(negedge clk);
        chk("t1_data", data_out, 100);
        chk("t1_phase0", phase, 0);
        chk("t1_valid", out_valid, 1);
        @(negedge clk);
        chk("t1_zero1", data_out, 0);
        chk("t1_phase1", phase, 1);
        @(negedge clk);
        chk("t1_zero2", data_out, 0);
        chk("t1_phase2", phase, 2);

        // Back-to-back stream.
        do_reset();
        send(1); send(2); send(3); send(-5);
        repeat (14) @(negedge clk);
        for (int i = 0; i < 12; i++) cap_chk("t2_stream", i, exp2[i]);

        // Underrun is sticky.
        do_reset();
        send(7);
        repeat (6) @(negedge clk);
        cap_chk("t3_s0", 0, 7);
        cap_chk("t3_s1", 1, 0);
        cap_chk("t3_s2", 2, 0);
        cap_chk("t3_s3", 3, 0);
        chk("t3_underrun", underrun, 1);
        send(9);
        repeat (8) @(negedge clk);
        chk("t3_underrun_sticky", underrun, 1);

        // Fill the FIFO; pops continue while full.
        do_reset();
        rdy_low = 0;
        for (int i = 0; i < 8; i++) send(20 + i);
        chk("t4_in_ready_fell", rdy_low > 0, 1);
        repeat (30) @(negedge clk);
        for (int i = 0; i < 8; i++) cap_chk("t4_order", 3 * i, 20 + i);

        // Extreme values pass bit-exact.
        do_reset();
        send(-32768);
        send(32767);
        repeat (8) @(negedge clk);
        cap_chk("t5_min", 0, -32768);
        cap_chk("t5_max", 3, 32767);

        // Asynchronous reset mid-stream at phase 1 with three samples queued.
        do_reset();
        for (int i = 0; i < 5; i++) send(11 + i);
        n = 0;
        while (!(mphase == 1 && mq.size() == 3) && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            checks++;
            failures++;
            $display("FAIL t6_setup: waited %0d cycles, required phase 1 with count 3", n);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_drop", out_valid, 0);
        chk("t6_data_zero", data_out, 0);
        chk("t6_phase_zero", phase, 0);
        chk("t6_in_ready", in_ready, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        cap.delete();
        repeat (8) @(negedge clk);
        chk("t6_idle", out_valid, 0);
        chk("t6_no_old", cap.size(), 0);

        // Randomized traffic with random gaps.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(int'($urandom_range(0, 65535)));
        end
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
